// File: rtl/mult_block_pkg.sv
// Shared constants, types and MISR step function for the mult_block self-test vehicle.
package mult_block_pkg;

   localparam int W = 16;

   typedef logic [W-1:0]   word_t;
   typedef logic [2*W-1:0] prod_t;

   localparam word_t SEED_A_DEF = 16'hACE1;
   localparam word_t SEED_B_DEF = 16'h1D2C;

   // Feedback tap masks: x^16+x^14+x^13+x^11+1 and x^16+x^15+x^13+x^4+1
   localparam word_t TAPS_A     = 16'hB400;
   localparam word_t TAPS_B     = 16'hD008;

   localparam word_t MISR_P_DEF = 16'h100B;

   function automatic word_t misr_step(input word_t s, input word_t d, input word_t poly);
      misr_step = {s[W-2:0], 1'b0} ^ (s[W-1] ? poly : '0) ^ d;
   endfunction

endpackage

// File: rtl/mult_block_lfsr16.sv
// 16-bit Fibonacci LFSR, shifts left, feedback is XOR of the masked taps.
module lfsr16
   import mult_block_pkg::*;
#(
   parameter word_t SEED = SEED_A_DEF,
   parameter word_t TAPS = TAPS_A
) (
   input  logic  clk,
   input  logic  reset,
   output word_t q
);

   always_ff @(posedge clk) begin
      if (!reset) q <= SEED;
      else        q <= {q[W-2:0], ^(q & TAPS)};
   end

endmodule

// File: rtl/mult_block.sv
// LFSR-fed 2-stage multiplier compacted into a MISR signature.
// Define MULT_BLOCK_SIGNED_EN for a two's-complement multiply.
module mult_block
   import mult_block_pkg::*;
#(
   parameter word_t SEED_A = SEED_A_DEF,
   parameter word_t SEED_B = SEED_B_DEF,
   parameter word_t MISR_P = MISR_P_DEF
) (
   input  logic  clk,
   input  logic  reset,
   output word_t signature
);

   word_t a;
   word_t b;
   prod_t p_reg;
   word_t f_reg;
   word_t misr;
   prod_t prod;

   lfsr16 #(.SEED(SEED_A), .TAPS(TAPS_A)) u_lfsr_a (
      .clk   (clk),
      .reset (reset),
      .q     (a)
   );

   lfsr16 #(.SEED(SEED_B), .TAPS(TAPS_B)) u_lfsr_b (
      .clk   (clk),
      .reset (reset),
      .q     (b)
   );

`ifdef MULT_BLOCK_SIGNED_EN
   assign prod = $unsigned($signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b}));
`else
   assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         p_reg <= '0;
         f_reg <= '0;
         misr  <= '0;
      end else begin
         p_reg <= prod;
         f_reg <= p_reg[2*W-1:W] ^ p_reg[W-1:0];
         misr  <= misr_step(misr, f_reg, MISR_P);
      end
   end

   assign signature = misr;

endmodule

// File: tb/tb_mult_block.sv
// Scoreboard bench for mult_block: independent equation model feeds an expected queue.
// Honours MULT_BLOCK_SIGNED_EN for the multiply and the edge-3 constant.
module tb_mult_block;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] signature;

   mult_block dut (
      .clk       (clk),
      .reset     (reset),
      .signature (signature)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [15:0] exp_q[$];
   logic [15:0] trace[100];

   logic [15:0] ma, mb, mf, mm;
   logic [31:0] mp;

`ifdef MULT_BLOCK_SIGNED_EN
   localparam logic [15:0] EDGE3 = 16'hC52B;
`else
   localparam logic [15:0] EDGE3 = 16'h201F;
`endif

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mul(input logic [15:0] x, input logic [15:0] y);
`ifdef MULT_BLOCK_SIGNED_EN
      longint sx, sy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      mul = 32'(sx * sy);
`else
      longint ux, uy;
      ux = longint'({16'h0, x});
      uy = longint'({16'h0, y});
      mul = 32'(ux * uy);
`endif
   endfunction

   task automatic model_edge(input logic rst);
      logic [15:0] na, nb, nf, nm;
      logic [31:0] np;
      if (!rst) begin
         na = 16'hACE1; nb = 16'h1D2C; np = '0; nf = '0; nm = '0;
      end else begin
         na = {ma[14:0], ma[15] ^ ma[13] ^ ma[12] ^ ma[10]};
         nb = {mb[14:0], mb[15] ^ mb[14] ^ mb[12] ^ mb[3]};
         np = mul(ma, mb);
         nf = mp[31:16] ^ mp[15:0];
         nm = {mm[14:0], 1'b0} ^ (mm[15] ? 16'h100B : 16'h0000) ^ mf;
      end
      ma = na; mb = nb; mp = np; mf = nf; mm = nm;
   endtask

   task automatic step(input logic rst, output logic [15:0] got);
      logic [15:0] e;
      reset = rst;
      model_edge(rst);
      exp_q.push_back(mm);
      @(posedge clk);
      #1;
      got = signature;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL sb_empty got=%h exp=none", got);
      end else begin
         e = exp_q.pop_front();
         check("sb", got, e);
      end
   endtask

   initial begin
      logic [15:0] got;
      ma = '0; mb = '0; mp = '0; mf = '0; mm = '0;

      for (int i = 0; i < 3; i++) begin
         step(1'b0, got);
         check("rst_hold", got, 16'h0000);
      end

      for (int i = 0; i < 100; i++) begin
         step(1'b1, got);
         trace[i] = got;
         if (i < 2) check("latency", got, 16'h0000);
         if (i == 2) check("edge3", got, EDGE3);
      end

      step(1'b0, got);
      check("pulse_rst", got, 16'h0000);

      for (int i = 0; i < 100; i++) begin
         step(1'b1, got);
         check("rerun", got, trace[i]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
